// File: rtl/traffic_pkg.sv
// Shared traffic-light types and constants: mode one-hot encodings, FSM states,
// default committed durations and the config-commit validity check.
package traffic_pkg;

  localparam int unsigned TIME_W = 7;

  localparam logic [2:0] AUTO_EN   = 3'b100;
  localparam logic [2:0] CONFIG_EN = 3'b010;
  localparam logic [2:0] MANUAL_EN = 3'b001;

  localparam logic [TIME_W-1:0] GREEN_DEF  = TIME_W'(25);
  localparam logic [TIME_W-1:0] YELLOW_DEF = TIME_W'(5);
  localparam logic [TIME_W-1:0] RED_DEF    = TIME_W'(30);
  localparam logic [TIME_W-1:0] TIME_MAX   = TIME_W'(99);

  typedef enum logic [1:0] {
    ST_AUTO   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_CONFIG = 2'd2,
    ST_CLEAR  = 2'd3
  } mode_state_e;

  typedef struct packed {
    logic [TIME_W-1:0] green;
    logic [TIME_W-1:0] red;
    logic [TIME_W-1:0] yellow;
  } time_set_t;

  localparam time_set_t TIME_DEF = '{green: GREEN_DEF, red: RED_DEF, yellow: YELLOW_DEF};

  // Nonzero, within range, and red must equal green + yellow without 7-bit wrap.
  function automatic logic commit_valid(input time_set_t t);
    logic [TIME_W:0] sum;
    sum = {1'b0, t.green} + {1'b0, t.yellow};
    return (t.green != '0) && (t.red != '0) && (t.yellow != '0) &&
           (t.green <= TIME_MAX) && (t.red <= TIME_MAX) && (t.yellow <= TIME_MAX) &&
           (sum == {1'b0, t.red});
  endfunction

  function automatic logic [2:0] mode_en_of(input mode_state_e s);
    case (s)
      ST_AUTO:   return AUTO_EN;
      ST_MANUAL: return MANUAL_EN;
      ST_CONFIG: return CONFIG_EN;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Button, proposed-time and mode/commit status bundle between the board side
// (master) and the mode sequencer (slave).
interface mode_sequencer_if;
  import traffic_pkg::*;

  logic              tick;
  logic              btn_mode;
  logic              btn_config;
  logic              btn_confirm;
  logic [TIME_W-1:0] green_mod;
  logic [TIME_W-1:0] red_mod;
  logic [TIME_W-1:0] yellow_mod;
  logic [2:0]        mode_en;
  logic              all_red;
  logic [TIME_W-1:0] green_time;
  logic [TIME_W-1:0] red_time;
  logic [TIME_W-1:0] yellow_time;
  logic              commit_ok;
  logic              commit_err;

  modport master (
    output tick, btn_mode, btn_config, btn_confirm, green_mod, red_mod, yellow_mod,
    input  mode_en, all_red, green_time, red_time, yellow_time, commit_ok, commit_err
  );

  modport slave (
    input  tick, btn_mode, btn_config, btn_confirm, green_mod, red_mod, yellow_mod,
    output mode_en, all_red, green_time, red_time, yellow_time, commit_ok, commit_err
  );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer, steady-level debounce and rising-edge press pulse.
// Raw edge to press pulse is DEB_CYCLES+3 clk cycles.
module button_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEB_CYCLES > 0) ? DEB_CYCLES - 1 : 0);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             level;
  logic             level_d;

  // Accept a new level only after it differs for DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= 2'b00;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      press   <= level & ~level_d;
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// AUTO/CONFIG/MANUAL mode FSM with all-red clearance and validated time commits.
// Optional CONFIG inactivity timeout: define MODE_SEQ_CFG_TIMEOUT_EN.
module mode_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned CLEAR_TICKS = 3
`ifdef MODE_SEQ_CFG_TIMEOUT_EN
  ,
  parameter int unsigned CFG_TIMEOUT = 30
`endif
) (
  input logic             clk,
  input logic             reset,
  mode_sequencer_if.slave bus
);

  localparam int unsigned CLR_W = (CLEAR_TICKS > 0) ? $clog2(CLEAR_TICKS + 1) : 1;
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_TICKS);

  logic mode_p, cfg_p, conf_p;
  logic timeout_c;

  mode_state_e      state_q, state_d, target_q, target_d;
  logic [CLR_W-1:0] clr_q, clr_d;
  time_set_t        times_q, times_d, proposal;
  logic [2:0]       mode_en_q, mode_en_d;
  logic             all_red_q, all_red_d;
  logic             ok_q, ok_d, err_q, err_d;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clk), .reset(reset), .raw(bus.btn_mode), .press(mode_p)
  );
  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_config (
    .clk(clk), .reset(reset), .raw(bus.btn_config), .press(cfg_p)
  );
  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_confirm (
    .clk(clk), .reset(reset), .raw(bus.btn_confirm), .press(conf_p)
  );

  assign proposal = '{green: bus.green_mod, red: bus.red_mod, yellow: bus.yellow_mod};

`ifdef MODE_SEQ_CFG_TIMEOUT_EN
  localparam int unsigned IDLE_W = (CFG_TIMEOUT > 0) ? $clog2(CFG_TIMEOUT + 1) : 1;
  logic [IDLE_W-1:0] idle_q;

  // Inactivity ticks while in CONFIG; any press or leaving CONFIG restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else if (state_q != ST_CONFIG || mode_p || cfg_p || conf_p) begin
      idle_q <= '0;
    end else if (bus.tick && !timeout_c) begin
      idle_q <= idle_q + IDLE_W'(1);
    end
  end

  assign timeout_c = (idle_q == IDLE_W'(CFG_TIMEOUT));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_AUTO;
      target_q  <= ST_AUTO;
      clr_q     <= '0;
      times_q   <= TIME_DEF;
      mode_en_q <= AUTO_EN;
      all_red_q <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      clr_q     <= clr_d;
      times_q   <= times_d;
      mode_en_q <= mode_en_d;
      all_red_q <= all_red_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    clr_d    = clr_q;
    times_d  = times_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_AUTO: begin
        if (mode_p) begin
          state_d  = ST_CLEAR;
          target_d = ST_MANUAL;
          clr_d    = CLR_LOAD;
        end else if (cfg_p) begin
          state_d  = ST_CLEAR;
          target_d = ST_CONFIG;
          clr_d    = CLR_LOAD;
        end
      end
      ST_MANUAL: begin
        if (mode_p) begin
          state_d  = ST_CLEAR;
          target_d = ST_AUTO;
          clr_d    = CLR_LOAD;
        end
      end
      ST_CONFIG: begin
        // Commit is evaluated even when the exit press lands in the same cycle.
        if (conf_p) begin
          if (commit_valid(proposal)) begin
            times_d = proposal;
            ok_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (cfg_p || timeout_c) begin
          state_d  = ST_CLEAR;
          target_d = ST_AUTO;
          clr_d    = CLR_LOAD;
        end
      end
      ST_CLEAR: begin
        if (clr_q == '0) begin
          state_d = target_q;
        end else if (bus.tick) begin
          clr_d = clr_q - CLR_W'(1);
        end
      end
      default: state_d = ST_AUTO;
    endcase

    mode_en_d = mode_en_of(state_d);
    all_red_d = (state_d == ST_CLEAR);
  end

  assign bus.mode_en     = mode_en_q;
  assign bus.all_red     = all_red_q;
  assign bus.green_time  = times_q.green;
  assign bus.red_time    = times_q.red;
  assign bus.yellow_time = times_q.yellow;
  assign bus.commit_ok   = ok_q;
  assign bus.commit_err  = err_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: mode transitions, clearance, debounce,
// and a table of commit vectors applied in CONFIG.
module tb_mode_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mode_sequencer_if bus ();

  mode_sequencer #(.DEB_CYCLES(16), .CLEAR_TICKS(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  bit saw_cfg = 1'b0;

  typedef struct {
    logic [6:0] g, r, y;
    bit         exp_ok;
    logic [6:0] eg, er, ey;
  } vec_t;

  // Count status pulses (in cycles) and note any CONFIG enable.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.commit_ok)  ok_cnt++;
      if (bus.commit_err) err_cnt++;
      if (bus.mode_en == 3'b010) saw_cfg = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_times(input string name, input logic [6:0] g, r, y);
    check(name, {11'd0, bus.green_time, bus.red_time, bus.yellow_time}, {11'd0, g, r, y});
  endtask

  task automatic press(input bit m, input bit c, input bit f);
    @(negedge clk);
    bus.btn_mode    = m;
    bus.btn_config  = c;
    bus.btn_confirm = f;
    repeat (25) @(negedge clk);
    bus.btn_mode    = 1'b0;
    bus.btn_config  = 1'b0;
    bus.btn_confirm = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic tick_pulse();
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic clear_ticks();
    repeat (3) tick_pulse();
    @(negedge clk);
  endtask

  vec_t vecs[10];

  initial begin
    int ok0, err0;
    vecs[0] = '{7'd20, 7'd24, 7'd4,  1'b1, 7'd20, 7'd24, 7'd4};
    vecs[1] = '{7'd20, 7'd30, 7'd4,  1'b0, 7'd20, 7'd24, 7'd4};
    vecs[2] = '{7'd0,  7'd5,  7'd5,  1'b0, 7'd20, 7'd24, 7'd4};
    vecs[3] = '{7'd10, 7'd10, 7'd0,  1'b0, 7'd20, 7'd24, 7'd4};
    vecs[4] = '{7'd60, 7'd120,7'd60, 1'b0, 7'd20, 7'd24, 7'd4};
    vecs[5] = '{7'd70, 7'd12, 7'd70, 1'b0, 7'd20, 7'd24, 7'd4};
    vecs[6] = '{7'd90, 7'd99, 7'd9,  1'b1, 7'd90, 7'd99, 7'd9};
    vecs[7] = '{7'd1,  7'd2,  7'd1,  1'b1, 7'd1,  7'd2,  7'd1};
    vecs[8] = '{7'd100,7'd110,7'd10, 1'b0, 7'd1,  7'd2,  7'd1};
    vecs[9] = '{7'd49, 7'd99, 7'd50, 1'b1, 7'd49, 7'd99, 7'd50};

    bus.tick = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_config = 1'b0;
    bus.btn_confirm = 1'b0;
    bus.green_mod = 7'd0;
    bus.red_mod = 7'd0;
    bus.yellow_mod = 7'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mode_en", 32'(bus.mode_en), 32'(3'b100));
    check("rst_all_red", 32'(bus.all_red), 32'd0);
    check_times("rst_times", 7'd25, 7'd30, 7'd5);
    check("rst_pulses", {30'd0, bus.commit_ok, bus.commit_err}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Mode press latency: press pulse at DEB+3, outputs one cycle later
    bus.btn_mode = 1'b1;
    repeat (19) @(negedge clk);
    check("lat_before", 32'(bus.mode_en), 32'(3'b100));
    @(negedge clk);
    check("lat_mode_en", 32'(bus.mode_en), 32'd0);
    check("lat_all_red", 32'(bus.all_red), 32'd1);
    repeat (5) @(negedge clk);
    bus.btn_mode = 1'b0;
    repeat (25) @(negedge clk);
    tick_pulse();
    tick_pulse();
    check("clr_2ticks", {28'd0, bus.all_red, bus.mode_en}, {28'd0, 1'b1, 3'b000});
    tick_pulse();
    check("clr_3ticks", {28'd0, bus.all_red, bus.mode_en}, {28'd0, 1'b1, 3'b000});
    @(negedge clk);
    check("to_manual", {28'd0, bus.all_red, bus.mode_en}, {28'd0, 1'b0, 3'b001});

    // MANUAL ignores config and confirm
    press(1'b0, 1'b1, 1'b1);
    check("manual_ignore", {28'd0, bus.all_red, bus.mode_en}, {28'd0, 1'b0, 3'b001});
    press(1'b1, 1'b0, 1'b0);
    clear_ticks();
    check("manual_to_auto", 32'(bus.mode_en), 32'(3'b100));

    // Simultaneous mode and config in AUTO: mode wins
    saw_cfg = 1'b0;
    press(1'b1, 1'b1, 1'b0);
    clear_ticks();
    check("both_mode_en", 32'(bus.mode_en), 32'(3'b001));
    check("both_no_cfg", 32'(saw_cfg), 32'd0);
    press(1'b1, 1'b0, 1'b0);
    clear_ticks();

    // Short glitch on config is rejected
    @(negedge clk);
    bus.btn_config = 1'b1;
    repeat (10) @(negedge clk);
    bus.btn_config = 1'b0;
    repeat (40) @(negedge clk);
    check("glitch", {28'd0, bus.all_red, bus.mode_en}, {28'd0, 1'b0, 3'b100});

    // Presses during CLEAR are ignored; target survives
    press(1'b0, 1'b1, 1'b0);
    check("clr_held", 32'(bus.all_red), 32'd1);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("clr_still", 32'(bus.all_red), 32'd1);
    clear_ticks();
    check("to_config", 32'(bus.mode_en), 32'(3'b010));
    press(1'b1, 1'b0, 1'b0);
    check("config_ign_mode", 32'(bus.mode_en), 32'(3'b010));

    // Commit vector table
    for (int i = 0; i < 10; i++) begin
      bus.green_mod  = vecs[i].g;
      bus.red_mod    = vecs[i].r;
      bus.yellow_mod = vecs[i].y;
      ok0 = ok_cnt;
      err0 = err_cnt;
      press(1'b0, 1'b0, 1'b1);
      check($sformatf("vec%0d_ok", i), 32'(ok_cnt - ok0), 32'(vecs[i].exp_ok));
      check($sformatf("vec%0d_err", i), 32'(err_cnt - err0), 32'(!vecs[i].exp_ok));
      check_times($sformatf("vec%0d_times", i), vecs[i].eg, vecs[i].er, vecs[i].ey);
    end

    // Confirm and config together: commit first, then exit to AUTO
    bus.green_mod = 7'd30;
    bus.red_mod = 7'd40;
    bus.yellow_mod = 7'd10;
    ok0 = ok_cnt;
    press(1'b0, 1'b1, 1'b1);
    check("exit_commit_ok", 32'(ok_cnt - ok0), 32'd1);
    check("exit_clear", 32'(bus.all_red), 32'd1);
    clear_ticks();
    check("exit_auto", 32'(bus.mode_en), 32'(3'b100));
    check_times("exit_times", 7'd30, 7'd40, 7'd10);

    // Reset mid-CLEAR discards the pending transition
    press(1'b1, 1'b0, 1'b0);
    check("pre_rst_clear", 32'(bus.all_red), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async", {28'd0, bus.all_red, bus.mode_en}, {28'd0, 1'b0, 3'b100});
    check_times("rst_mid_times", 7'd25, 7'd30, 7'd5);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) tick_pulse();
    repeat (3) @(negedge clk);
    check("rst_no_pending", {28'd0, bus.all_red, bus.mode_en}, {28'd0, 1'b0, 3'b100});

    // Reset mid-debounce discards the partial count
    bus.btn_mode = 1'b1;
    repeat (12) @(negedge clk);
    bus.btn_mode = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_deb", {28'd0, bus.all_red, bus.mode_en}, {28'd0, 1'b0, 3'b100});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
